// File: rtl/ext_gcd_pkg.sv
// Shared types and sizing for the binary extended-GCD engine.
package ext_gcd_pkg;

    localparam int DEF_NBITS = 256;

    // Each coefficient magnitude stays below the operand range. The 3 extra bits
    // cover the sign and the transient A+v0 / B-u0 sums.
    function automatic int cw_of(input int nbits);
        return nbits + 3;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_REDUCE,
        S_NORM,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        CM_HOLD,
        CM_HALVE,
        CM_HCOR,
        CM_SUB
    } coef_mode_e;

endpackage

// File: rtl/ext_gcd_coef_upd.sv
// Combinational Bezout coefficient-pair update: hold, halve, halve with
// (+v0, -u0) correction, or subtract the opposite pair.
module ext_gcd_coef_upd
    import ext_gcd_pkg::*;
#(
    parameter int NBITS = DEF_NBITS,
    parameter int CW    = cw_of(NBITS)
) (
    input  logic signed [CW-1:0]    a_in,
    input  logic signed [CW-1:0]    b_in,
    input  logic signed [CW-1:0]    sub_a,
    input  logic signed [CW-1:0]    sub_b,
    input  logic        [NBITS-1:0] u0,
    input  logic        [NBITS-1:0] v0,
    input  coef_mode_e              mode,
    output logic signed [CW-1:0]    a_out,
    output logic signed [CW-1:0]    b_out
);

    logic signed [CW-1:0] u0e, v0e, ta, tb;

    assign u0e = $signed({{(CW-NBITS){1'b0}}, u0});
    assign v0e = $signed({{(CW-NBITS){1'b0}}, v0});
    assign ta  = a_in + v0e;
    assign tb  = b_in - u0e;

    always_comb begin
        a_out = a_in;
        b_out = b_in;
        case (mode)
            CM_HALVE: begin
                a_out = a_in >>> 1;
                b_out = b_in >>> 1;
            end
            CM_HCOR: begin
                a_out = ta >>> 1;
                b_out = tb >>> 1;
            end
            CM_SUB: begin
                a_out = a_in - sub_a;
                b_out = b_in - sub_b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ext_gcd_engine.sv
// Binary extended-GCD engine: gcd(x,y) and signed a,b with a*x + b*y = gcd.
// Define EXT_GCD_MODINV_EN to add the inv/inv_ok modular-inverse outputs.
module ext_gcd_engine
    import ext_gcd_pkg::*;
#(
    parameter int NBITS = DEF_NBITS,
    parameter int CW    = cw_of(NBITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NBITS-1:0]     x,
    input  logic [NBITS-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NBITS-1:0]     gcd,
    output logic signed [CW-1:0] a,
    output logic signed [CW-1:0] b,
    output logic                 err,
`ifdef EXT_GCD_MODINV_EN
    output logic [NBITS-1:0]     inv,
    output logic                 inv_ok,
`endif
    output logic                 busy
);

    localparam int KW = $clog2(NBITS) + 1;

    state_e               state;
    logic [NBITS-1:0]     u, v, u0, v0;
    logic [KW-1:0]        k;
    logic signed [CW-1:0] ca, cb, cc, cd;
    logic signed [CW-1:0] xa_n, xb_n, ya_n, yb_n;
    coef_mode_e           xm, ym;
`ifdef EXT_GCD_MODINV_EN
    logic [NBITS-1:0]     y_r;
    logic signed [CW-1:0] a_mod;
    assign a_mod = a + $signed({{(CW-NBITS){1'b0}}, y_r});
`endif

    // (ca,cb) tracks u = ca*u0 + cb*v0; (cc,cd) tracks v the same way.
    always_comb begin
        xm = CM_HOLD;
        ym = CM_HOLD;
        if (state == S_REDUCE && u != v) begin
            if (!u[0])      xm = (ca[0] | cb[0]) ? CM_HCOR : CM_HALVE;
            else if (!v[0]) ym = (cc[0] | cd[0]) ? CM_HCOR : CM_HALVE;
            else if (u > v) xm = CM_SUB;
            else            ym = CM_SUB;
        end
    end

    ext_gcd_coef_upd #(.NBITS(NBITS), .CW(CW)) u_upd_x (
        .a_in(ca), .b_in(cb), .sub_a(cc), .sub_b(cd),
        .u0(u0), .v0(v0), .mode(xm), .a_out(xa_n), .b_out(xb_n)
    );

    ext_gcd_coef_upd #(.NBITS(NBITS), .CW(CW)) u_upd_y (
        .a_in(cc), .b_in(cd), .sub_a(ca), .sub_b(cb),
        .u0(u0), .v0(v0), .mode(ym), .a_out(ya_n), .b_out(yb_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            gcd       <= '0;
            a         <= '0;
            b         <= '0;
            k         <= '0;
            u         <= '0;
            v         <= '0;
            u0        <= '0;
            v0        <= '0;
            ca        <= '0;
            cb        <= '0;
            cc        <= '0;
            cd        <= '0;
`ifdef EXT_GCD_MODINV_EN
            y_r       <= '0;
            inv       <= '0;
            inv_ok    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    err      <= 1'b0;
                    k        <= '0;
                    u        <= x;
                    v        <= y;
                    ca       <= CW'(1);
                    cb       <= '0;
                    cc       <= '0;
                    cd       <= CW'(1);
`ifdef EXT_GCD_MODINV_EN
                    y_r      <= y;
`endif
                    if (x == '0 || y == '0) begin
                        gcd <= (x == '0) ? y : x;
                        a   <= (x != '0) ? CW'(1) : '0;
                        b   <= (x == '0 && y != '0) ? CW'(1) : '0;
                        err <= (x == '0 && y == '0);
`ifdef EXT_GCD_MODINV_EN
                        state <= S_NORM;
`else
                        state     <= S_DONE;
                        out_valid <= 1'b1;
`endif
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!u[0] && !v[0]) begin
                        u <= u >> 1;
                        v <= v >> 1;
                        k <= k + 1'b1;
                    end else begin
                        u0    <= u;
                        v0    <= v;
                        state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    ca <= xa_n;
                    cb <= xb_n;
                    cc <= ya_n;
                    cd <= yb_n;
                    if (u == v) begin
                        gcd <= u << k;
                        a   <= ca;
                        b   <= cb;
`ifdef EXT_GCD_MODINV_EN
                        state <= S_NORM;
`else
                        state     <= S_DONE;
                        out_valid <= 1'b1;
`endif
                    end else if (!u[0]) u <= u >> 1;
                    else if (!v[0])     v <= v >> 1;
                    else if (u > v)     u <= u - v;
                    else                v <= v - u;
                end
`ifdef EXT_GCD_MODINV_EN
                S_NORM: begin
                    if (gcd == NBITS'(1) && y_r > NBITS'(1)) begin
                        inv_ok <= 1'b1;
                        inv    <= a[CW-1] ? a_mod[NBITS-1:0] : a[NBITS-1:0];
                    end else begin
                        inv_ok <= 1'b0;
                        inv    <= '0;
                    end
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
`endif
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_gcd_engine.sv
// Directed self-checking bench for ext_gcd_engine (NBITS=64).
module tb_ext_gcd_engine;

    localparam int NB = 64;
    localparam int CW = NB + 3;
    localparam int WW = 2 * NB + 8;
`ifdef EXT_GCD_MODINV_EN
    localparam int LAT = 3 * NB + 3;
`else
    localparam int LAT = 3 * NB + 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst, in_valid, in_ready, out_valid, out_ready, err, busy;
    logic [NB-1:0]        x, y, gcd;
    logic signed [CW-1:0] a, b;
`ifdef EXT_GCD_MODINV_EN
    logic [NB-1:0]        inv;
    logic                 inv_ok;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ext_gcd_engine #(.NBITS(NB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .gcd(gcd), .a(a), .b(b), .err(err),
`ifdef EXT_GCD_MODINV_EN
        .inv(inv), .inv_ok(inv_ok),
`endif
        .busy(busy)
    );

    function automatic logic signed [WW-1:0] bez(input logic signed [CW-1:0] ca, cb,
                                                 input logic [NB-1:0] xx, yy);
        logic signed [WW-1:0] ea, eb, ex, ey;
        ea = ca;
        eb = cb;
        ex = $signed({{(WW-NB){1'b0}}, xx});
        ey = $signed({{(WW-NB){1'b0}}, yy});
        return ea * ex + eb * ey;
    endfunction

    function automatic logic signed [WW-1:0] ext(input logic [NB-1:0] g);
        return $signed({{(WW-NB){1'b0}}, g});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [NB-1:0] xx, yy);
        x = xx;
        y = yy;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < LAT) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b want=0", err); end
        checks++; if (gcd !== '0) begin errors++; $display("FAIL rst_gcd got=%0d want=0", gcd); end
        checks++; if (a !== '0 || b !== '0) begin errors++; $display("FAIL rst_ab got=%0d,%0d want=0,0", a, b); end
    endtask

    task automatic test_basic();
        int cyc;
        start(NB'(240), NB'(46));
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b/%b want=1/0", busy, in_ready); end
        wait_out(cyc);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%0d cycles want<=%0d", cyc, LAT); end
        checks++; if (gcd !== NB'(2)) begin errors++; $display("FAIL basic_gcd got=%0d want=2", gcd); end
        checks++; if (bez(a, b, NB'(240), NB'(46)) !== ext(NB'(2))) begin errors++; $display("FAIL basic_bezout a=%0d b=%0d want a*240+b*46=2", a, b); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b want=0", err); end
        consume();
    endtask

    task automatic test_zero();
        int cyc;
        start(NB'(17), NB'(0));
        wait_out(cyc);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zy_valid got=%b want=1", out_valid); end
        checks++; if (gcd !== NB'(17) || a !== CW'(1) || b !== '0 || err !== 1'b0) begin
            errors++; $display("FAIL zy_result got gcd=%0d a=%0d b=%0d err=%b want 17,1,0,0", gcd, a, b, err); end
        consume();
        start(NB'(0), NB'(9));
        wait_out(cyc);
        checks++; if (gcd !== NB'(9) || a !== '0 || b !== CW'(1) || err !== 1'b0) begin
            errors++; $display("FAIL zx_result got gcd=%0d a=%0d b=%0d err=%b want 9,0,1,0", gcd, a, b, err); end
        consume();
        start(NB'(0), NB'(0));
        wait_out(cyc);
        checks++; if (gcd !== '0 || a !== '0 || b !== '0 || err !== 1'b1) begin
            errors++; $display("FAIL zz_result got gcd=%0d a=%0d b=%0d err=%b want 0,0,0,1", gcd, a, b, err); end
        consume();
    endtask

    task automatic test_full_width();
        int cyc;
        logic [NB-1:0] hx, hy;
        hx = {1'b1, {(NB-1){1'b0}}};
        hy = {1'b0, {(NB-1){1'b1}}};
        start(hx, hy);
        wait_out(cyc);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency got=%0d cycles want<=%0d", cyc, LAT); end
        checks++; if (gcd !== NB'(1)) begin errors++; $display("FAIL full_gcd got=%0d want=1", gcd); end
        checks++; if (bez(a, b, hx, hy) !== ext(NB'(1))) begin errors++; $display("FAIL full_bezout a=%0d b=%0d want identity=1", a, b); end
        consume();
    endtask

    task automatic test_exact_coef();
        int cyc;
        start(NB'(3), NB'(11));
        wait_out(cyc);
        checks++; if (gcd !== NB'(1) || a !== CW'(4) || b !== -CW'(1)) begin
            errors++; $display("FAIL coef_3_11 got gcd=%0d a=%0d b=%0d want 1,4,-1", gcd, a, b); end
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        start(NB'(12), NB'(18));
        wait_out(cyc);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b want=1", out_valid); end
        bad = 0;
        x = NB'(7);
        y = NB'(0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || gcd !== NB'(6) ||
                bez(a, b, NB'(12), NB'(18)) !== ext(NB'(6))) bad++;
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got=%0d bad cycles want=0 (gcd=%0d a=%0d b=%0d)", bad, gcd, a, b); end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b vld=%b busy=%b want 1,0,0", in_ready, out_valid, busy); end
        tick();
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_ignored got busy=%b vld=%b want 0,0", busy, out_valid); end
    endtask

    task automatic test_rst_mid();
        int cyc;
        int seen;
        start(NB'(240), NB'(46));
        tick(); tick(); tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_rst got rdy=%b vld=%b busy=%b want 1,0,0", in_ready, out_valid, busy); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_discard got=%0d valid cycles want=0", seen); end
        start(NB'(35), NB'(15));
        wait_out(cyc);
        checks++; if (gcd !== NB'(5) || bez(a, b, NB'(35), NB'(15)) !== ext(NB'(5))) begin
            errors++; $display("FAIL mid_after got gcd=%0d a=%0d b=%0d want gcd=5 identity", gcd, a, b); end
        consume();
    endtask

`ifdef EXT_GCD_MODINV_EN
    task automatic test_modinv();
        int cyc;
        start(NB'(3), NB'(11));
        wait_out(cyc);
        checks++; if (inv !== NB'(4) || inv_ok !== 1'b1) begin
            errors++; $display("FAIL inv_3_11 got inv=%0d ok=%b want 4,1", inv, inv_ok); end
        consume();
        start(NB'(4), NB'(8));
        wait_out(cyc);
        checks++; if (inv !== '0 || inv_ok !== 1'b0) begin
            errors++; $display("FAIL inv_4_8 got inv=%0d ok=%b want 0,0", inv, inv_ok); end
        consume();
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        y = '0;
        test_reset();
        test_basic();
        test_zero();
        test_full_width();
        test_exact_coef();
        test_backpressure();
        test_rst_mid();
`ifdef EXT_GCD_MODINV_EN
        test_modinv();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
